// File: rtl/hc595_pkg.sv
// Shared constants for the 74HC595 display scanner.
//   SEG_*      : common-anode, active-low segment codes, decimal point off
//   SEL_IDLE   : digit-select byte with every digit disabled
//   DIG_NUM    : number of digit slots in one frame
//   BIN_W      : width of the binary value fed to the BCD converter
//   BCD_DIGITS : number of BCD digits produced by the converter
//   state_e    : scanner FSM states
//   seg_code() : BCD digit to segment byte, anything above 9 is blank
package hc595_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEL_IDLE  = 8'hFF;

  // The decimal point is never lit, so the first bit of every word is 1.
  localparam logic DP_OFF = 1'b1;

  localparam int DIG_NUM    = 6;
  localparam int BIN_W      = 20;
  localparam int BCD_DIGITS = 5;

  typedef enum logic [1:0] {
    CONV  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } state_e;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one iteration per clock.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : load din and begin a conversion
//   din          : binary input, must be <= 99999 so it fits five digits
//   done         : high in the cycle whose closing edge completes the last
//                  iteration; b0..b4 are final from the following cycle
//   b0..b4       : BCD digits, b0 least significant
// Handshake: start is a one-cycle request; done follows 20 cycles after the
// cycle start was high. A start while busy restarts the conversion.
module bin2bcd_seq
  import hc595_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] din,
  output logic             done,
  output logic [3:0]       b0,
  output logic [3:0]       b1,
  output logic [3:0]       b2,
  output logic [3:0]       b3,
  output logic [3:0]       b4
);

  logic [BIN_W-1:0]        bin_q, bin_d;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [4:0]              cnt_q, cnt_d;

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    adj   = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    if (start) begin
      bin_d = din;
      bcd_d = '0;
      cnt_d = 5'(BIN_W);
    end else if (cnt_q != 5'd0) begin
      bcd_d = {adj[4*BCD_DIGITS-2:0], bin_q[BIN_W-1]};
      bin_d = {bin_q[BIN_W-2:0], 1'b0};
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 5'd1);
  assign b0   = bcd_q[3:0];
  assign b1   = bcd_q[7:4];
  assign b2   = bcd_q[11:8];
  assign b3   = bcd_q[15:12];
  assign b4   = bcd_q[19:16];

endmodule

// File: rtl/hc595_disp_scan.sv
// Six-digit seven-segment scanner driving two cascaded 74HC595s.
// Each frame snapshots disp_data/flag, converts to BCD, then for each digit
// shifts out {seg_n, sel_n} MSB first, pulses the latch and holds the slot.
//   CLK_DIV    : clk cycles per sh_cp half-period and per st_cp pulse
//   SCAN_CYC   : clk cycles per digit slot
//   clk        : block clock
//   reset_n    : asynchronous active-low reset
//   disp_data  : value to display (saturated to 99999)
//   flag       : parameter index 0..4, shown as 1..5 on digit 5
//   sh_cp      : 595 shift clock (data sampled on rise)
//   st_cp      : 595 storage clock
//   ds         : 595 serial data
//   frame_done : one-cycle pulse after the digit-5 slot ends
module hc595_disp_scan
  import hc595_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SCAN_CYC = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:0] disp_data,
  input  logic [2:0]  flag,
  output logic        sh_cp,
  output logic        st_cp,
  output logic        ds,
  output logic        frame_done
);

  if (CLK_DIV < 1 || SCAN_CYC < 33*CLK_DIV + 2) begin : g_param_check
    $error("hc595_disp_scan: need CLK_DIV >= 1 and SCAN_CYC >= 33*CLK_DIV+2");
  end

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int TMR_W = $clog2(SCAN_CYC + 1);

  state_e           state_q, state_d;
  logic [2:0]       digit_q, digit_d;
  logic [2:0]       flg_q, flg_d;
  logic             conv_busy_q, conv_busy_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic             sh_cp_q, sh_cp_d;
  logic             st_cp_q, st_cp_d;
  logic             ds_q, ds_d;
  logic             frame_done_q, frame_done_d;

  logic             bcd_start, bcd_done;
  logic [3:0]       b0, b1, b2, b3, b4;
  logic [19:0]      din_sat;
  logic [7:0]       seg_n, sel_n;
  logic [15:0]      word;
  logic [3:0]       nxt_idx;
  logic             div_end;

  assign din_sat = (disp_data > 20'd99999) ? 20'd99999 : disp_data;

  bin2bcd_seq u_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (bcd_start),
    .din     (din_sat),
    .done    (bcd_done),
    .b0      (b0),
    .b1      (b1),
    .b2      (b2),
    .b3      (b3),
    .b4      (b4)
  );

  // Segment byte for the current digit; a digit is blank when it and every
  // more significant digit are zero, except digit 0.
  always_comb begin
    seg_n = SEG_BLANK;
    case (digit_q)
      3'd0: seg_n = seg_code(b0);
      3'd1: seg_n = ((b4 | b3 | b2 | b1) != 4'd0) ? seg_code(b1) : SEG_BLANK;
      3'd2: seg_n = ((b4 | b3 | b2) != 4'd0) ? seg_code(b2) : SEG_BLANK;
      3'd3: seg_n = ((b4 | b3) != 4'd0) ? seg_code(b3) : SEG_BLANK;
      3'd4: seg_n = (b4 != 4'd0) ? seg_code(b4) : SEG_BLANK;
      3'd5: seg_n = (flg_q <= 3'd4) ? seg_code({1'b0, flg_q} + 4'd1) : SEG_BLANK;
      default: seg_n = SEG_BLANK;
    endcase
    sel_n = SEL_IDLE & ~(8'b1 << digit_q);
    word  = {seg_n, sel_n};
  end

  assign nxt_idx = 4'd14 - bit_q;
  assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    flg_d        = flg_q;
    conv_busy_d  = conv_busy_q;
    timer_d      = timer_q;
    div_d        = div_q;
    bit_d        = bit_q;
    sh_cp_d      = sh_cp_q;
    st_cp_d      = st_cp_q;
    ds_d         = ds_q;
    frame_done_d = 1'b0;
    bcd_start    = 1'b0;
    case (state_q)
      CONV: begin
        if (!conv_busy_q) begin
          bcd_start   = 1'b1;
          flg_d       = flag;
          conv_busy_d = 1'b1;
        end else if (bcd_done) begin
          conv_busy_d = 1'b0;
          state_d     = SHIFT;
          timer_d     = '0;
          div_d       = '0;
          bit_d       = '0;
          sh_cp_d     = 1'b0;
          ds_d        = DP_OFF;
        end
      end
      SHIFT: begin
        timer_d = timer_q + TMR_W'(1);
        if (div_end) begin
          div_d = '0;
          if (!sh_cp_q) begin
            sh_cp_d = 1'b1;
          end else begin
            // Falling edge of sh_cp: present the next bit, or finish the word.
            sh_cp_d = 1'b0;
            if (bit_q == 4'd15) begin
              state_d = LATCH;
              st_cp_d = 1'b1;
              ds_d    = 1'b0;
            end else begin
              bit_d = bit_q + 4'd1;
              ds_d  = word[nxt_idx];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        timer_d = timer_q + TMR_W'(1);
        if (div_end) begin
          div_d   = '0;
          st_cp_d = 1'b0;
          state_d = HOLD;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HOLD: begin
        if (timer_q == TMR_W'(SCAN_CYC - 1)) begin
          timer_d = '0;
          if (digit_q == 3'(DIG_NUM - 1)) begin
            digit_d      = '0;
            frame_done_d = 1'b1;
            state_d      = CONV;
          end else begin
            digit_d = digit_q + 3'd1;
            state_d = SHIFT;
            div_d   = '0;
            bit_d   = '0;
            sh_cp_d = 1'b0;
            ds_d    = DP_OFF;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = CONV;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CONV;
      digit_q      <= '0;
      flg_q        <= '0;
      conv_busy_q  <= 1'b0;
      timer_q      <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      sh_cp_q      <= 1'b0;
      st_cp_q      <= 1'b0;
      ds_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      flg_q        <= flg_d;
      conv_busy_q  <= conv_busy_d;
      timer_q      <= timer_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      sh_cp_q      <= sh_cp_d;
      st_cp_q      <= st_cp_d;
      ds_q         <= ds_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sh_cp      = sh_cp_q;
  assign st_cp      = st_cp_q;
  assign ds         = ds_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hc595_disp_scan.sv
// Directed bench for hc595_disp_scan with CLK_DIV=2, SCAN_CYC=200.
// A pin monitor rebuilds each 16-bit word from sh_cp/ds and compares it on
// every st_cp rise against the expected queue.
module tb_hc595_disp_scan;

  localparam int CLK_DIV   = 2;
  localparam int SCAN_CYC  = 200;
  localparam int FRAME_CYC = 6*SCAN_CYC + 21;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] disp_data = '0;
  logic [2:0]  flag = '0;
  logic        sh_cp, st_cp, ds, frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  hc595_disp_scan #(.CLK_DIV(CLK_DIV), .SCAN_CYC(SCAN_CYC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .disp_data  (disp_data),
    .flag       (flag),
    .sh_cp      (sh_cp),
    .st_cp      (st_cp),
    .ds         (ds),
    .frame_done (frame_done)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // pin monitor / scoreboard
  logic        prev_sh = 1'b0, prev_st = 1'b0, ds_at_rise = 1'b0;
  logic        stable_bad = 1'b0, have_prev_st = 1'b0, fd_seen = 1'b0;
  logic [15:0] shreg = '0;
  int          rises = 0, cyc = 0, last_st_cyc = 0, words_in_frame = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset_n) begin
      prev_sh = 1'b0; prev_st = 1'b0; stable_bad = 1'b0;
      have_prev_st = 1'b0; fd_seen = 1'b0; shreg = '0;
      rises = 0; words_in_frame = 0;
    end else begin
      if (sh_cp && !prev_sh) begin
        shreg      = {shreg[14:0], ds};
        rises++;
        ds_at_rise = ds;
      end else if (sh_cp && prev_sh && ds !== ds_at_rise) begin
        stable_bad = 1'b1;
      end
      if (frame_done) begin
        fd_seen        = 1'b1;
        words_in_frame = 0;
      end
      if (st_cp && !prev_st) begin
        check("sh_low_at_latch", sh_cp, 0);
        check("rises_per_word", rises, 16);
        check("ds_stable", stable_bad, 0);
        if (have_prev_st)
          check("slot_period", cyc - last_st_cyc, fd_seen ? SCAN_CYC + 21 : SCAN_CYC);
        if (exp_q.size() > 0)
          check($sformatf("word%0d", words_in_frame), shreg, exp_q.pop_front());
        last_st_cyc  = cyc;
        have_prev_st = 1'b1;
        fd_seen      = 1'b0;
        rises        = 0;
        stable_bad   = 1'b0;
        words_in_frame++;
      end
      prev_sh = sh_cp;
      prev_st = st_cp;
    end
  end

  // driver tasks
  task automatic push_frame(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5);
    exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2);
    exp_q.push_back(w3); exp_q.push_back(w4); exp_q.push_back(w5);
  endtask

  task automatic wait_frame_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (frame_done) break;
    end
    check("frame_done_seen", frame_done, 1);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk); #1;
    end
    check("exp_drained", exp_q.size(), 0);
  endtask

  task automatic count_to_sh_rise(input string tag);
    int n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (sh_cp) break;
    end
    check(tag, n, 21 + CLK_DIV);
  endtask

  // stimulus
  initial begin
    int n;
    // reset with disp_data = 0, flag = 0
    repeat (3) @(negedge clk);
    #1;
    check("reset_pins", {sh_cp, st_cp, ds, frame_done}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    push_frame(16'hC0FE, 16'hFFFD, 16'hFFFB, 16'hFFF7, 16'hFFEF, 16'hF9DF);
    count_to_sh_rise("first_sh_rise");
    wait_drain(3000);

    // 300 / flag 2, plus frame period
    disp_data = 20'd300; flag = 3'd2;
    wait_frame_done(3000);
    push_frame(16'hC0FE, 16'hC0FD, 16'hB0FB, 16'hFFF7, 16'hFFEF, 16'hB0DF);
    @(negedge clk); #1;
    check("frame_done_width", frame_done, 0);
    n = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      n++;
      if (frame_done) break;
    end
    check("frame_period", n, FRAME_CYC);
    wait_drain(1);

    // saturation and out-of-range flag
    disp_data = 20'd123456; flag = 3'd7;
    wait_frame_done(3000);
    push_frame(16'h90FE, 16'h90FD, 16'h90FB, 16'h90F7, 16'h90EF, 16'hFFDF);
    wait_drain(3000);

    // input change during digit 2 is ignored until the next frame
    disp_data = 20'd300; flag = 3'd2;
    wait_frame_done(3000);
    push_frame(16'hC0FE, 16'hC0FD, 16'hB0FB, 16'hFFF7, 16'hFFEF, 16'hB0DF);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 3) break;
      @(negedge clk); #1;
    end
    check("mid_frame_sync", exp_q.size(), 3);
    disp_data = 20'd800;
    wait_drain(3000);
    wait_frame_done(3000);
    push_frame(16'hC0FE, 16'hC0FD, 16'h80FB, 16'hFFF7, 16'hFFEF, 16'hB0DF);
    wait_drain(3000);

    // asynchronous reset during the bit-7 shift of digit 3
    wait_frame_done(3000);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (words_in_frame == 3 && rises == 7 && !sh_cp) break;
    end
    check("bit7_sync", rises, 7);
    check("ds_before_reset", ds, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_pins", {sh_cp, st_cp, ds, frame_done}, 0);
    repeat (3) @(negedge clk);
    #1;
    check("held_reset_pins", {sh_cp, st_cp, ds, frame_done}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    push_frame(16'hC0FE, 16'hC0FD, 16'h80FB, 16'hFFF7, 16'hFFEF, 16'hB0DF);
    count_to_sh_rise("restart_sh_rise");
    wait_drain(3000);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hc595_disp_scan.md
# hc595_disp_scan

Time-multiplexed display scheduler for the 6-digit seven-segment module driven through two cascaded 74HC595 shift registers. It snapshots the parameter value `disp_data` and the parameter selector `flag` once per frame and converts the value to BCD sequentially. It then scans the six digits, serialising one 16-bit segment/select word per digit onto the 595 pins. It sits between the parameter-control block and the board pins.

## Interface
- `CLK_DIV`, 4: clk cycles per half-period of `sh_cp` and per `st_cp` high pulse; legal range ≥1.
- `SCAN_CYC`, 50000: clk cycles per digit slot (1 ms at 50 MHz); must satisfy SCAN_CYC ≥ 33*CLK_DIV+2 (elaboration-time check).
- `clk`  in  1  block clock, 50 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `disp_data`  in  20  unsigned value to display.
- `flag`  in  3  parameter index, 0..4.
- `sh_cp`  out  1  595 shift clock; data is sampled on its rising edge.
- `st_cp`  out  1  595 storage/latch clock.
- `ds`  out  1  595 serial data, MSB first.
- `frame_done`  out  1  one-cycle pulse when the digit-5 slot ends.

## Operation
- FSM states: CONV, SHIFT, LATCH, HOLD.
- Reset: all outputs 0, digit index 0, state CONV.
- CONV:
  - On entry, latch `disp_data` into `val` and `flag` into `flg`.
  - Saturate: if `val` > 99999, use 99999.
  - Run a 20-iteration shift-add-3 conversion, one iteration per clk, to give BCD b4..b0.
  - Then go to SHIFT with digit index 0.
- Word per digit = {seg_n[7:0], sel_n[7:0]}, shifted bit 15 first.
  - sel_n: bit k = 0 only for digit k (digit 0 is rightmost); bits 7:6 are always 1.
  - seg_n: common-anode, active-low, dp off. Codes: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, blank FF.
  - Digits 0..4 show b0..b4. Leading zeros are blanked, but digit 0 is never blanked.
  - Digit 5 shows `flg`+1 (1..5). If `flg` > 4, digit 5 shows blank.
- SHIFT, for each of 16 bits:
  - `ds` updates while `sh_cp` = 0.
  - `sh_cp` stays low for CLK_DIV cycles, then high for CLK_DIV cycles.
- LATCH: `st_cp` = 1 for CLK_DIV cycles; `ds` = 0.
- HOLD:
  - A slot timer starts at 0 on SHIFT entry.
  - HOLD exits when the timer reaches SCAN_CYC-1.
  - On exit, the digit index increments and the next state is SHIFT.
  - After digit 5, the index wraps to 0, `frame_done` pulses, and the next state is CONV.
- `disp_data`/`flag` changes mid-frame are ignored until the next CONV entry.
- Reset asserted mid-operation: outputs go to 0 immediately (asynchronous); after release, restart at CONV.

## Timing
- After reset release: CONV takes 21 cycles (1 latch + 20 iterations). The first `sh_cp` rise is at cycle 21+CLK_DIV.
- Per digit: SHIFT 32*CLK_DIV cycles, LATCH CLK_DIV cycles, remainder in HOLD. The slot is exactly SCAN_CYC cycles.
- Frame length = 6*SCAN_CYC + 21 cycles.
- All outputs are registered; no combinational path from inputs to pins.
- `st_cp` never rises while `sh_cp` = 1. `sh_cp` is 0 at the start of each LATCH.

## Structure
- `hc595_pkg`: seg code constants SEG_0..SEG_9, SEG_BLANK, SEL_IDLE = 8'hFF, FSM state enum, constant DIG_NUM = 6.
- Sub-module `bin2bcd_seq`: start/done handshake, 20-bit input, five BCD outputs, 20 cycles from start to done. The top-level module owns the FSM, slot timer and shifter.

## Test plan
Run with CLK_DIV=2 and SCAN_CYC=200; the bench captures 595 words on each `st_cp` rise.
- Reset and release with `disp_data` = 0 → all pins 0 during reset. Words: C0FE, FFFD, FFFB, FFF7, FFEF, then F9DF (`flag` = 0 → "1").
- `disp_data` = 300, `flag` = 2 → C0FE, C0FD, B0FB, FFF7, FFEF, B0DF. `frame_done` pulses every 1221 cycles.
- `disp_data` = 123456 → digits 0..4 read 9,9,9,9,9 (90xx); `flag` = 7 → digit 5 is FFDF.
- `disp_data` changed 300 → 800 during digit 2 → the rest of that frame still shows 300; the next frame shows C0FE, C0FD, 80FB.
- `reset_n` low during the bit-7 shift of digit 3 → pins 0 within the same cycle. After release, the sequence restarts at digit 0 and the first `sh_cp` rise is 23 cycles later.
- Protocol checker throughout: exactly 16 `sh_cp` rises between `st_cp` pulses; `ds` stable while `sh_cp` is high; slot period = 200 cycles.
